// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC and a synchronous-read instruction ROM and
// presents {PC, instr, valid} to the IF/ID register one cycle after each address is issued.
module fetch_stage #(
    parameter int                 PC_W       = 10,
    parameter int                 INSTR_W    = 9,
    parameter int                 IMEM_DEPTH = 1024,
    parameter logic [PC_W-1:0]    START_PC   = '0,
    parameter logic [INSTR_W-1:0] HALT_INSTR = '1,
    // ROM image, produced from the machine-code file by the build flow
    parameter logic [INSTR_W-1:0] IMEM_INIT [IMEM_DEPTH] = '{default: '0}
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               start,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    PC_out,
    output logic [INSTR_W-1:0] instr_out,
    output logic               valid_out,
    output logic               done
);

    localparam int AW = $clog2(IMEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_e;

    state_e             state_q,     state_d;
    logic [PC_W-1:0]    fetch_pc_q,  fetch_pc_d;
    logic [PC_W-1:0]    out_pc_q,    out_pc_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;
    logic               out_valid_q, out_valid_d;
    logic [INSTR_W-1:0] rom_data;

    // Addresses beyond the populated ROM read as zero.
    always_comb begin
        rom_data = '0;
        if (32'(fetch_pc_q) < IMEM_DEPTH) begin
            rom_data = IMEM_INIT[fetch_pc_q[AW-1:0]];
        end
    end

    // NOTE: every next-state signal gets a hold default first, so no path leaves one
    // unassigned and no latch can be inferred.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            S_IDLE: begin
                out_valid_d = 1'b0;
                if (start) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                // A redirect beats stall and halt: whatever sits on the outputs is wrong-path.
                if (branch_taken) begin
                    fetch_pc_d  = branch_target;
                    out_valid_d = 1'b0;
                end else if (stall) begin
                    state_d = S_RUN;
                end else if (out_valid_q && (out_instr_q == HALT_INSTR)) begin
                    state_d     = S_HALT;
                    out_valid_d = 1'b0;
                end else begin
                    out_instr_d = rom_data;
                    out_pc_d    = fetch_pc_q;
                    out_valid_d = 1'b1;
                    fetch_pc_d  = fetch_pc_q + 1'b1;
                end
            end

            S_HALT: begin
                out_valid_d = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= S_IDLE;
            fetch_pc_q  <= START_PC;
            out_pc_q    <= '0;
            out_instr_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign PC_out    = out_pc_q;
    assign instr_out = out_instr_q;
    assign valid_out = out_valid_q;
    assign done      = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-cycle stimulus tables, expected outputs queued
// when each cycle's inputs are driven and popped/compared after the clock edge.
module tb_fetch_stage;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;

    localparam logic [INSTR_W-1:0] ROM_IMG [1024] = '{
        0: 9'h001, 1: 9'h002, 2: 9'h003, 3: 9'h004, 4: 9'h1FF,
        5: 9'h015, 6: 9'h016, 7: 9'h017,
        512: 9'h0C8, 513: 9'h0C9, 514: 9'h0CA,
        1022: 9'h07E, 1023: 9'h07F,
        default: 9'h0A5
    };

    typedef struct packed {
        logic               rst;
        logic               start;
        logic               stall;
        logic               br;
        logic [PC_W-1:0]    tgt;
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               valid;
        logic               done;
        logic               dc;     // compare PC/instr too, not only valid/done
    } step_t;

    logic               CLK = 1'b0;
    logic               reset;
    logic               start;
    logic               stall;
    logic               branch_taken;
    logic [PC_W-1:0]    branch_target;
    logic [PC_W-1:0]    PC_out;
    logic [INSTR_W-1:0] instr_out;
    logic               valid_out;
    logic               done;

    step_t sb[$];
    int    tests_run    = 0;
    int    tests_failed = 0;

    always #5 CLK = ~CLK;

    fetch_stage #(
        .PC_W      (PC_W),
        .INSTR_W   (INSTR_W),
        .IMEM_DEPTH(1024),
        .START_PC  (10'd0),
        .HALT_INSTR(9'h1FF),
        .IMEM_INIT (ROM_IMG)
    ) dut (
        .CLK          (CLK),
        .reset        (reset),
        .start        (start),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .PC_out       (PC_out),
        .instr_out    (instr_out),
        .valid_out    (valid_out),
        .done         (done)
    );

    function automatic logic [INSTR_W-1:0] rom(input logic [PC_W-1:0] a);
        return ROM_IMG[a];
    endfunction

    function automatic step_t mk(input logic rst, input logic st, input logic sl, input logic br,
                                 input logic [PC_W-1:0] tgt, input logic [PC_W-1:0] pc,
                                 input logic [INSTR_W-1:0] ins, input logic v, input logic d,
                                 input logic dc);
        step_t s;
        s = '{rst: rst, start: st, stall: sl, br: br, tgt: tgt, pc: pc, instr: ins,
              valid: v, done: d, dc: dc};
        return s;
    endfunction

    // Fetched-instruction expectation with all inputs idle.
    function automatic step_t fx(input logic [PC_W-1:0] pc);
        return mk(0, 0, 0, 0, '0, pc, rom(pc), 1, 0, 1);
    endfunction

    // Drive one cycle of inputs, queue its expectation, advance past the edge.
    task automatic apply(input step_t s);
        reset         = s.rst;
        start         = s.start;
        stall         = s.stall;
        branch_taken  = s.br;
        branch_target = s.tgt;
        sb.push_back(s);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        step_t q[$];
        step_t e;
        q.push_back(mk(1, 0, 0, 0, '0, '0, '0, 0, 0, 1));
        q.push_back(mk(1, 1, 1, 1, 10'h155, '0, '0, 0, 0, 1));
        foreach (q[i]) begin
            apply(q[i]);
            e = sb.pop_front();
            tests_run++;
            if (e.dc ? ({PC_out, instr_out, valid_out, done} !== {e.pc, e.instr, e.valid, e.done})
                     : ({valid_out, done} !== {e.valid, e.done})) begin
                tests_failed++;
                $display("FAIL reset[%0d]: got pc=%h instr=%h valid=%b done=%b, want pc=%h instr=%h valid=%b done=%b",
                         i, PC_out, instr_out, valid_out, done, e.pc, e.instr, e.valid, e.done);
            end
        end
    endtask

    task automatic test_startup();
        step_t q[$];
        step_t e;
        q.push_back(mk(0, 1, 0, 0, '0, '0, '0, 0, 0, 1));   // start edge: no fetch yet
        q.push_back(fx(10'd0));
        q.push_back(fx(10'd1));
        q.push_back(fx(10'd2));
        foreach (q[i]) begin
            apply(q[i]);
            e = sb.pop_front();
            tests_run++;
            if (e.dc ? ({PC_out, instr_out, valid_out, done} !== {e.pc, e.instr, e.valid, e.done})
                     : ({valid_out, done} !== {e.valid, e.done})) begin
                tests_failed++;
                $display("FAIL startup[%0d]: got pc=%h instr=%h valid=%b done=%b, want pc=%h instr=%h valid=%b done=%b",
                         i, PC_out, instr_out, valid_out, done, e.pc, e.instr, e.valid, e.done);
            end
        end
    endtask

    task automatic test_stall();
        step_t q[$];
        step_t e;
        q.push_back(mk(0, 0, 0, 1, 10'd5, '0, '0, 0, 0, 0));
        q.push_back(fx(10'd5));
        for (int k = 0; k < 3; k++) q.push_back(mk(0, 0, 1, 0, '0, 10'd5, rom(10'd5), 1, 0, 1));
        q.push_back(fx(10'd6));
        foreach (q[i]) begin
            apply(q[i]);
            e = sb.pop_front();
            tests_run++;
            if (e.dc ? ({PC_out, instr_out, valid_out, done} !== {e.pc, e.instr, e.valid, e.done})
                     : ({valid_out, done} !== {e.valid, e.done})) begin
                tests_failed++;
                $display("FAIL stall[%0d]: got pc=%h instr=%h valid=%b done=%b, want pc=%h instr=%h valid=%b done=%b",
                         i, PC_out, instr_out, valid_out, done, e.pc, e.instr, e.valid, e.done);
            end
        end
    endtask

    task automatic test_branch();
        step_t q[$];
        step_t e;
        q.push_back(fx(10'd7));
        q.push_back(mk(0, 0, 0, 1, 10'h200, '0, '0, 0, 0, 0));
        q.push_back(fx(10'h200));
        q.push_back(fx(10'h201));
        foreach (q[i]) begin
            apply(q[i]);
            e = sb.pop_front();
            tests_run++;
            if (e.dc ? ({PC_out, instr_out, valid_out, done} !== {e.pc, e.instr, e.valid, e.done})
                     : ({valid_out, done} !== {e.valid, e.done})) begin
                tests_failed++;
                $display("FAIL branch[%0d]: got pc=%h instr=%h valid=%b done=%b, want pc=%h instr=%h valid=%b done=%b",
                         i, PC_out, instr_out, valid_out, done, e.pc, e.instr, e.valid, e.done);
            end
        end
    endtask

    task automatic test_branch_stall_halt();
        step_t q[$];
        step_t e;
        q.push_back(mk(0, 0, 1, 1, 10'h200, '0, '0, 0, 0, 0));   // redirect beats stall
        q.push_back(fx(10'h200));
        q.push_back(mk(0, 0, 0, 1, 10'd3, '0, '0, 0, 0, 0));
        q.push_back(fx(10'd3));
        q.push_back(fx(10'd4));                                  // halt shown
        q.push_back(mk(0, 0, 0, 1, 10'h202, '0, '0, 0, 0, 0));   // redirect beats halt
        q.push_back(fx(10'h202));
        q.push_back(mk(0, 0, 0, 1, 10'd4, '0, '0, 0, 0, 0));
        q.push_back(fx(10'd4));
        q.push_back(mk(0, 0, 0, 0, '0, '0, '0, 0, 1, 0));        // enters HALT
        q.push_back(mk(0, 1, 0, 0, '0, '0, '0, 0, 1, 0));
        q.push_back(mk(0, 0, 1, 0, '0, '0, '0, 0, 1, 0));
        q.push_back(mk(0, 1, 0, 1, 10'd7, '0, '0, 0, 1, 0));
        q.push_back(mk(0, 0, 0, 0, '0, '0, '0, 0, 1, 0));
        foreach (q[i]) begin
            apply(q[i]);
            e = sb.pop_front();
            tests_run++;
            if (e.dc ? ({PC_out, instr_out, valid_out, done} !== {e.pc, e.instr, e.valid, e.done})
                     : ({valid_out, done} !== {e.valid, e.done})) begin
                tests_failed++;
                $display("FAIL branch_stall_halt[%0d]: got pc=%h instr=%h valid=%b done=%b, want pc=%h instr=%h valid=%b done=%b",
                         i, PC_out, instr_out, valid_out, done, e.pc, e.instr, e.valid, e.done);
            end
        end
    endtask

    task automatic test_halt_reset();
        step_t q[$];
        step_t e;
        q.push_back(mk(1, 0, 0, 0, '0, '0, '0, 0, 0, 1));
        q.push_back(mk(0, 1, 0, 0, '0, '0, '0, 0, 0, 1));
        q.push_back(fx(10'd0));
        q.push_back(fx(10'd1));
        foreach (q[i]) begin
            apply(q[i]);
            e = sb.pop_front();
            tests_run++;
            if (e.dc ? ({PC_out, instr_out, valid_out, done} !== {e.pc, e.instr, e.valid, e.done})
                     : ({valid_out, done} !== {e.valid, e.done})) begin
                tests_failed++;
                $display("FAIL halt_reset[%0d]: got pc=%h instr=%h valid=%b done=%b, want pc=%h instr=%h valid=%b done=%b",
                         i, PC_out, instr_out, valid_out, done, e.pc, e.instr, e.valid, e.done);
            end
        end
    endtask

    task automatic test_wrap();
        step_t q[$];
        step_t e;
        q.push_back(mk(0, 0, 0, 1, 10'd1022, '0, '0, 0, 0, 0));
        q.push_back(fx(10'd1022));
        q.push_back(fx(10'd1023));
        q.push_back(fx(10'd0));
        q.push_back(fx(10'd1));
        foreach (q[i]) begin
            apply(q[i]);
            e = sb.pop_front();
            tests_run++;
            if (e.dc ? ({PC_out, instr_out, valid_out, done} !== {e.pc, e.instr, e.valid, e.done})
                     : ({valid_out, done} !== {e.valid, e.done})) begin
                tests_failed++;
                $display("FAIL wrap[%0d]: got pc=%h instr=%h valid=%b done=%b, want pc=%h instr=%h valid=%b done=%b",
                         i, PC_out, instr_out, valid_out, done, e.pc, e.instr, e.valid, e.done);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        step_t q[$];
        step_t e;
        q.push_back(mk(1, 0, 1, 1, 10'h200, '0, '0, 0, 0, 1));
        q.push_back(mk(0, 0, 0, 0, '0, '0, '0, 0, 0, 1));
        q.push_back(mk(0, 0, 1, 1, 10'h200, '0, '0, 0, 0, 1));   // IDLE ignores stall/branch
        q.push_back(mk(0, 1, 0, 0, '0, '0, '0, 0, 0, 1));
        q.push_back(fx(10'd0));
        q.push_back(fx(10'd1));
        foreach (q[i]) begin
            apply(q[i]);
            e = sb.pop_front();
            tests_run++;
            if (e.dc ? ({PC_out, instr_out, valid_out, done} !== {e.pc, e.instr, e.valid, e.done})
                     : ({valid_out, done} !== {e.valid, e.done})) begin
                tests_failed++;
                $display("FAIL reset_mid_run[%0d]: got pc=%h instr=%h valid=%b done=%b, want pc=%h instr=%h valid=%b done=%b",
                         i, PC_out, instr_out, valid_out, done, e.pc, e.instr, e.valid, e.done);
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        test_reset();
        test_startup();
        test_stall();
        test_branch();
        test_branch_stall_halt();
        test_halt_reset();
        test_wrap();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
